riscv_ic_msg_rx_queue: RTL and testbench

Per-hart receive endpoint of the inter-core messaging fabric. Sits between the fabric's delivery port and the core. It accepts `inter_core_msg_t` packets and filters them by destination hart. Interrupt messages are converted into a sticky IPI-pending flag; all other valid opcodes are buffered in an in-order queue drained by the core.

---
 rtl/riscv_inter_core_types_pkg.sv | 40 ++++
 rtl/riscv_ic_msg_fifo.sv | 66 ++++++
 rtl/riscv_ic_msg_rx_queue.sv | 137 +++++++++++++
 tb/tb_riscv_ic_msg_rx_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_inter_core_types_pkg.sv
// Shared types for the inter-core messaging fabric: message struct, opcodes,
// hart-ID width, maximum receive-queue depth and performance-counter width.
package riscv_inter_core_types_pkg;

  localparam int HART_ID_WIDTH       = 4;
  localparam int MAX_MSG_QUEUE_DEPTH = 16;
  localparam int IC_MSG_DATA_WIDTH   = 32;
  localparam int IC_PERF_CNT_WIDTH   = 32;

  typedef enum logic [2:0] {
    IC_MSG_IDLE          = 3'd0,
    IC_MSG_INTERRUPT     = 3'd1,
    IC_MSG_CACHE_INV     = 3'd2,
    IC_MSG_TLB_SHOOTDOWN = 3'd3,
    IC_MSG_DATA          = 3'd4,
    IC_MSG_BARRIER       = 3'd5
  } inter_core_msg_opcode_e;

  typedef struct packed {
    logic                          valid;
    inter_core_msg_opcode_e        opcode;
    logic [HART_ID_WIDTH-1:0]      src_hart;
    logic [HART_ID_WIDTH-1:0]      dst_hart;
    logic [IC_MSG_DATA_WIDTH-1:0]  data;
  } inter_core_msg_t;

  localparam int IC_MSG_WIDTH = $bits(inter_core_msg_t);

  // Saturating increment used by the performance counters.
  function automatic logic [IC_PERF_CNT_WIDTH-1:0] perf_sat_inc(
    input logic [IC_PERF_CNT_WIDTH-1:0] value
  );
    if (value == {IC_PERF_CNT_WIDTH{1'b1}}) begin
      return value;
    end else begin
      return value + {{(IC_PERF_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/riscv_ic_msg_fifo.sv
// Generic synchronous FIFO with a count-based full/empty. Read data is forced
// to zero while empty so the head never shows stale storage.
module riscv_ic_msg_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_r == CNT_MAX);
  assign empty_o   = (count_r == {CNT_W{1'b0}});
  assign count_o   = count_r;
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign rdata_o   = empty_o ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Pointer and occupancy state; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; emptied logically by the pointer reset, contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata_i;
    end
  end

endmodule

// File: rtl/riscv_ic_msg_rx_queue.sv
// Per-hart receive endpoint: filters by destination hart, turns interrupts into a
// sticky IPI flag and queues other messages. Perf counters: RISCV_IC_RX_PERF_EN.
module riscv_ic_msg_rx_queue
  import riscv_inter_core_types_pkg::*;
#(
  parameter logic [HART_ID_WIDTH-1:0] HART_ID     = {HART_ID_WIDTH{1'b0}},
  parameter int                       QUEUE_DEPTH = MAX_MSG_QUEUE_DEPTH,
  localparam int                      CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  inter_core_msg_t              net_msg_i,
  output logic                         net_ready_o,
  output inter_core_msg_t              core_msg_o,
  input  logic                         core_ready_i,
  output logic                         ipi_pending_o,
  output logic [HART_ID_WIDTH-1:0]     ipi_src_o,
  input  logic                         ipi_clear_i,
  output logic                         misroute_o,
  output logic [CNT_W-1:0]             q_count_o,
  output logic [IC_PERF_CNT_WIDTH-1:0] perf_rx_o,
  output logic [IC_PERF_CNT_WIDTH-1:0] perf_stall_o
);

  logic                     accept_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     ipi_set_s;
  logic                     misroute_set_s;
  logic                     rx_hit_s;
  logic                     full_s;
  logic                     empty_s;
  inter_core_msg_t          wdata_s;
  inter_core_msg_t          head_s;
  logic                     misroute_r;
  logic                     ipi_pending_r;
  logic [HART_ID_WIDTH-1:0] ipi_src_r;

  // Ready depends only on the registered occupancy, never on the incoming message.
  assign net_ready_o   = !full_s;
  assign accept_s      = net_msg_i.valid && net_ready_o;
  assign pop_s         = !empty_s && core_ready_i;
  assign core_msg_o    = head_s;
  assign ipi_pending_o = ipi_pending_r;
  assign ipi_src_o     = ipi_src_r;
  assign misroute_o    = misroute_r;

  // Classify an accepted message: misroute, idle, interrupt or queued.
  always_comb begin
    push_s         = 1'b0;
    ipi_set_s      = 1'b0;
    misroute_set_s = 1'b0;
    rx_hit_s       = 1'b0;
    if (accept_s) begin
      if (net_msg_i.dst_hart != HART_ID) begin
        misroute_set_s = 1'b1;
      end else if (net_msg_i.opcode == IC_MSG_IDLE) begin
        push_s = 1'b0;
      end else if (net_msg_i.opcode == IC_MSG_INTERRUPT) begin
        ipi_set_s = 1'b1;
        rx_hit_s  = 1'b1;
      end else begin
        push_s   = 1'b1;
        rx_hit_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Stored entries always carry valid=1 so the head's valid tracks occupancy.
  always_comb begin
    wdata_s       = net_msg_i;
    wdata_s.valid = 1'b1;
  end

  riscv_ic_msg_fifo #(
    .WIDTH (IC_MSG_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wdata_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (q_count_o)
  );

  // IPI flag and source; a new IPI beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ipi_pending_r <= 1'b0;
      ipi_src_r     <= {HART_ID_WIDTH{1'b0}};
      misroute_r    <= 1'b0;
    end else begin
      misroute_r <= misroute_set_s;
      if (ipi_set_s) begin
        ipi_pending_r <= 1'b1;
        ipi_src_r     <= net_msg_i.src_hart;
      end else if (ipi_clear_i) begin
        ipi_pending_r <= 1'b0;
      end
    end
  end

`ifdef RISCV_IC_RX_PERF_EN
  logic                         stall_s;
  logic [IC_PERF_CNT_WIDTH-1:0] perf_rx_r;
  logic [IC_PERF_CNT_WIDTH-1:0] perf_stall_r;

  assign stall_s      = net_msg_i.valid && !net_ready_o;
  assign perf_rx_o    = perf_rx_r;
  assign perf_stall_o = perf_stall_r;

  // Saturating receive and back-pressure counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_rx_r    <= {IC_PERF_CNT_WIDTH{1'b0}};
      perf_stall_r <= {IC_PERF_CNT_WIDTH{1'b0}};
    end else begin
      if (rx_hit_s) begin
        perf_rx_r <= perf_sat_inc(perf_rx_r);
      end
      if (stall_s) begin
        perf_stall_r <= perf_sat_inc(perf_stall_r);
      end
    end
  end
`else
  assign perf_rx_o    = {IC_PERF_CNT_WIDTH{1'b0}};
  assign perf_stall_o = {IC_PERF_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_riscv_ic_msg_rx_queue.sv
// Scoreboard bench for riscv_ic_msg_rx_queue: directed scenarios plus random traffic
// against a queue-based reference model; a negedge monitor compares every cycle.
module tb_riscv_ic_msg_rx_queue;
  import riscv_inter_core_types_pkg::*;

  localparam logic [HART_ID_WIDTH-1:0] HART  = 4'd1;
  localparam int                       DEPTH = 16;
`ifdef RISCV_IC_RX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_ni;
  inter_core_msg_t net_msg;
  logic            net_ready;
  inter_core_msg_t core_msg;
  logic            core_ready;
  logic            ipi_pending;
  logic [3:0]      ipi_src;
  logic            ipi_clear;
  logic            misroute;
  logic [4:0]      q_count;
  logic [31:0]     perf_rx;
  logic [31:0]     perf_stall;

  int checks   = 0;
  int failures = 0;

  riscv_ic_msg_rx_queue #(.HART_ID(HART), .QUEUE_DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .net_msg_i     (net_msg),
    .net_ready_o   (net_ready),
    .core_msg_o    (core_msg),
    .core_ready_i  (core_ready),
    .ipi_pending_o (ipi_pending),
    .ipi_src_o     (ipi_src),
    .ipi_clear_i   (ipi_clear),
    .misroute_o    (misroute),
    .q_count_o     (q_count),
    .perf_rx_o     (perf_rx),
    .perf_stall_o  (perf_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  inter_core_msg_t exp_q[$];
  int              m_count;
  logic            m_ipi;
  logic [3:0]      m_src;
  logic            m_mis;
  logic [31:0]     m_rx;
  logic [31:0]     m_stall;
  logic            m_acc, m_pop, m_for_me, m_push, m_set, m_hit;
  inter_core_msg_t m_entry;

  assign m_acc    = net_msg.valid && (m_count != DEPTH);
  assign m_pop    = (m_count != 0) && core_ready;
  assign m_for_me = net_msg.dst_hart == HART;
  assign m_hit    = m_acc && m_for_me && (net_msg.opcode != IC_MSG_IDLE);
  assign m_set    = m_hit && (net_msg.opcode == IC_MSG_INTERRUPT);
  assign m_push   = m_hit && (net_msg.opcode != IC_MSG_INTERRUPT);
  always_comb begin
    m_entry       = net_msg;
    m_entry.valid = 1'b1;
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q.delete();
      m_count <= 0;
      m_ipi   <= 1'b0;
      m_src   <= 4'd0;
      m_mis   <= 1'b0;
      m_rx    <= 32'd0;
      m_stall <= 32'd0;
    end else begin
      m_mis <= m_acc && !m_for_me;
      if (m_hit && m_rx != 32'hFFFF_FFFF) m_rx <= m_rx + 32'd1;
      if (m_set) begin
        m_ipi <= 1'b1;
        m_src <= net_msg.src_hart;
      end else if (ipi_clear) begin
        m_ipi <= 1'b0;
      end
      if (m_push) exp_q.push_back(m_entry);
      if (net_msg.valid && m_count == DEPTH && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 32'd1;
      m_count <= m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_ni) begin
      chk("q_count", 64'(q_count), 64'(m_count));
      chk("net_ready", 64'(net_ready), 64'(m_count != DEPTH));
      chk("ipi_pending", 64'(ipi_pending), 64'(m_ipi));
      chk("ipi_src", 64'(ipi_src), 64'(m_src));
      chk("misroute", 64'(misroute), 64'(m_mis));
      chk("perf_rx", 64'(perf_rx), PERF ? 64'(m_rx) : 64'd0);
      chk("perf_stall", 64'(perf_stall), PERF ? 64'(m_stall) : 64'd0);
      if (core_msg.valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_head", 64'(core_msg), 64'd0);
        end else if (core_ready) begin
          chk("pop_data", 64'(core_msg), 64'(exp_q.pop_front()));
        end else begin
          chk("head_data", 64'(core_msg), 64'(exp_q[0]));
        end
      end else begin
        chk("empty_head_zero", 64'(core_msg), 64'd0);
        chk("empty_model", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit v, input inter_core_msg_opcode_e op, input logic [3:0] src,
                       input logic [3:0] dst, input logic [31:0] data, input bit rdy, input bit clr);
    net_msg.valid    = v;
    net_msg.opcode   = op;
    net_msg.src_hart = src;
    net_msg.dst_hart = dst;
    net_msg.data     = data;
    core_ready       = rdy;
    ipi_clear        = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, IC_MSG_IDLE, 4'd0, 4'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(net_ready), 64'd1);
    chk({tag, "_core_msg"}, 64'(core_msg), 64'd0);
    chk({tag, "_ipi"}, 64'(ipi_pending), 64'd0);
    chk({tag, "_src"}, 64'(ipi_src), 64'd0);
    chk({tag, "_mis"}, 64'(misroute), 64'd0);
    chk({tag, "_count"}, 64'(q_count), 64'd0);
    chk({tag, "_prx"}, 64'(perf_rx), 64'd0);
    chk({tag, "_pstall"}, 64'(perf_stall), 64'd0);
  endtask

  inter_core_msg_opcode_e ops [6] = '{IC_MSG_IDLE, IC_MSG_INTERRUPT, IC_MSG_CACHE_INV,
                                      IC_MSG_TLB_SHOOTDOWN, IC_MSG_DATA, IC_MSG_BARRIER};

  initial begin
    logic [31:0] order [3];
    order = '{32'h11, 32'h22, 32'h33};
    rst_ni  = 1'b0;
    net_msg = '0;
    core_ready = 1'b0;
    ipi_clear  = 1'b0;
    #12;
    chk_reset_outputs("rst0");
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Queue order
    for (int i = 0; i < 3; i++) drive(1'b1, IC_MSG_CACHE_INV, 4'd0, HART, order[i], 1'b0, 1'b0);
    chk("order_count", 64'(q_count), 64'd3);
    chk("order_head", 64'(core_msg.data), 64'h11);
    for (int i = 0; i < 3; i++) begin
      chk("order_seq", 64'(core_msg.data), 64'(order[i]));
      idle(1'b1);
    end
    chk("order_drained", 64'(core_msg), 64'd0);

    // Full / back-pressure
    for (int i = 0; i < DEPTH; i++) drive(1'b1, IC_MSG_DATA, 4'd5, HART, 32'h100 + i, 1'b0, 1'b0);
    chk("full_ready", 64'(net_ready), 64'd0);
    chk("full_count", 64'(q_count), 64'd16);
    for (int i = 0; i < 4; i++) drive(1'b1, IC_MSG_DATA, 4'd5, HART, 32'hAA, 1'b0, 1'b0);
    chk("stall4", 64'(perf_stall), PERF ? 64'd4 : 64'd0);
    drive(1'b1, IC_MSG_DATA, 4'd5, HART, 32'hAA, 1'b1, 1'b0);
    chk("ready_after_pop", 64'(net_ready), 64'd1);
    drive(1'b1, IC_MSG_DATA, 4'd5, HART, 32'hAA, 1'b0, 1'b0);
    chk("held_accepted", 64'(q_count), 64'd16);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    // IPI path
    drive(1'b1, IC_MSG_INTERRUPT, 4'd2, HART, 32'd0, 1'b0, 1'b0);
    chk("ipi_set", 64'(ipi_pending), 64'd1);
    chk("ipi_src2", 64'(ipi_src), 64'd2);
    chk("ipi_noqueue", 64'(q_count), 64'd0);
    drive(1'b1, IC_MSG_INTERRUPT, 4'd3, HART, 32'd0, 1'b0, 1'b1);
    chk("ipi_set_wins", 64'(ipi_pending), 64'd1);
    chk("ipi_src3", 64'(ipi_src), 64'd3);
    drive(1'b0, IC_MSG_IDLE, 4'd0, 4'd0, 32'd0, 1'b0, 1'b1);
    chk("ipi_cleared", 64'(ipi_pending), 64'd0);

    // Filtering
    drive(1'b1, IC_MSG_CACHE_INV, 4'd0, HART + 4'd1, 32'h55, 1'b0, 1'b0);
    chk("misroute_pulse", 64'(misroute), 64'd1);
    chk("misroute_noq", 64'(q_count), 64'd0);
    drive(1'b1, IC_MSG_IDLE, 4'd0, HART, 32'h66, 1'b0, 1'b0);
    chk("misroute_one", 64'(misroute), 64'd0);
    chk("idle_noq", 64'(q_count), 64'd0);
    chk("idle_perf", 64'(perf_rx), PERF ? 64'd22 : 64'd0);
    idle(1'b0);
    chk("idle_nopulse", 64'(misroute), 64'd0);

    // Simultaneous push/pop across pointer wrap
    for (int i = 0; i < 5; i++) drive(1'b1, IC_MSG_TLB_SHOOTDOWN, 4'd7, HART, 32'h200 + i, 1'b0, 1'b0);
    for (int i = 5; i < 20; i++) begin
      drive(1'b1, IC_MSG_TLB_SHOOTDOWN, 4'd7, HART, 32'h200 + i, 1'b1, 1'b0);
      chk("pushpop_count", 64'(q_count), 64'd5);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Async reset mid-operation
    for (int i = 0; i < 7; i++) drive(1'b1, IC_MSG_BARRIER, 4'd4, HART, 32'h300 + i, 1'b0, 1'b0);
    drive(1'b1, IC_MSG_INTERRUPT, 4'd6, HART, 32'd0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(q_count), 64'd7);
    chk("pre_rst_ipi", 64'(ipi_pending), 64'd1);
    idle(1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk_reset_outputs("arst");
    #4 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, IC_MSG_CACHE_INV, 4'd1, HART, 32'h77, 1'b0, 1'b0);
    chk("post_rst_count", 64'(q_count), 64'd1);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit rdy_bias;
      rdy_bias = ((i / 60) % 2) == 0;
      drive($urandom_range(0, 9) < 7, ops[$urandom_range(0, 5)], 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 8) ? HART : 4'($urandom_range(0, 15)),
            $urandom, rdy_bias ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2),
            $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    chk("final_drained", 64'(q_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
